// File: rtl/mac_decimator_coeff_sequencer.sv
// Coefficient bank store and reload sequencer feeding the single-MAC decimator.
// Optional delay-line flush after each reload is enabled by defining COEFF_FLUSH_EN.
module mac_decimator_coeff_sequencer #(
  parameter int unsigned DataW    = 18,
  parameter int unsigned CoeffW   = 18,
  parameter int unsigned NumTaps  = 16,
  parameter int unsigned AddrW    = 4,
  parameter int unsigned NumBanks = 2,
  parameter int unsigned BankW    = 1,
  parameter int unsigned FlushLen = 16,
  parameter int unsigned FlushGap = 16
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              HostWr_i,
  input  logic [BankW-1:0]  HostBank_i,
  input  logic [AddrW-1:0]  HostAddr_i,
  input  logic [CoeffW-1:0] HostData_i,
  input  logic              Load_i,
  input  logic [BankW-1:0]  BankSel_i,
  input  logic [DataW-1:0]  Data_i,
  input  logic              DataNd_i,
  output logic [DataW-1:0]  DecData_o,
  output logic              DecNd_o,
  output logic [AddrW-1:0]  CoeffAddr_o,
  output logic [CoeffW-1:0] CoeffData_o,
  output logic              CoeffWr_o,
  output logic              Busy_o,
  output logic              Done_o,
  output logic [BankW-1:0]  ActiveBank_o,
  output logic [15:0]       DropCnt_o
);

  localparam int unsigned CntW = AddrW + 1;

`ifdef COEFF_FLUSH_EN
  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;
  localparam int unsigned GapW   = $clog2(FlushGap + 1);
  localparam int unsigned PulseW = $clog2(FlushLen + 1);
  logic [GapW-1:0]   gapCnt_q;
  logic [PulseW-1:0] pulseCnt_q;
`else
  typedef enum logic [1:0] {StIdle, StLoad} state_e;
  logic unusedFlushCfg;
  assign unusedFlushCfg = ^{FlushLen, FlushGap};
`endif

  state_e            state_q;
  logic [BankW-1:0]  bank_q;
  logic [CntW-1:0]   tapCnt_q;
  logic [AddrW-1:0]  tapAddr;
  logic              lastTap;
  logic [CoeffW-1:0] store [NumBanks][NumTaps];

  assign tapAddr = tapCnt_q[AddrW-1:0];
  assign lastTap = (tapCnt_q == CntW'(NumTaps - 1));

  // Not reset; a same-cycle loader read sees the old entry.
  always_ff @(posedge Clk_i) begin
    if (HostWr_i) store[HostBank_i][HostAddr_i] <= HostData_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q      <= StIdle;
      bank_q       <= '0;
      tapCnt_q     <= '0;
      DecData_o    <= '0;
      DecNd_o      <= 1'b0;
      CoeffAddr_o  <= '0;
      CoeffData_o  <= '0;
      CoeffWr_o    <= 1'b0;
      Busy_o       <= 1'b0;
      Done_o       <= 1'b0;
      ActiveBank_o <= '0;
      DropCnt_o    <= '0;
`ifdef COEFF_FLUSH_EN
      gapCnt_q     <= '0;
      pulseCnt_q   <= '0;
`endif
    end else begin
      CoeffWr_o <= 1'b0;
      Done_o    <= 1'b0;
      if (state_q != StIdle && DataNd_i && DropCnt_o != 16'hFFFF) begin
        DropCnt_o <= DropCnt_o + 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          DecData_o <= Data_i;
          DecNd_o   <= DataNd_i;
          Busy_o    <= 1'b0;
          if (Load_i) begin
            bank_q   <= BankSel_i;
            tapCnt_q <= '0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          DecData_o <= '0;
          DecNd_o   <= 1'b0;
          // Terminal count only reached without flush; the flush path leaves on lastTap.
          if (tapCnt_q != CntW'(NumTaps)) begin
            Busy_o      <= 1'b1;
            CoeffWr_o   <= 1'b1;
            CoeffAddr_o <= tapAddr;
            CoeffData_o <= store[bank_q][tapAddr];
            tapCnt_q    <= tapCnt_q + CntW'(1);
`ifdef COEFF_FLUSH_EN
            if (lastTap) begin
              state_q    <= StFlush;
              gapCnt_q   <= '0;
              pulseCnt_q <= '0;
            end
`endif
          end else begin
            Busy_o       <= 1'b0;
            Done_o       <= 1'b1;
            ActiveBank_o <= bank_q;
            state_q      <= StIdle;
          end
        end
`ifdef COEFF_FLUSH_EN
        StFlush: begin
          DecData_o <= '0;
          if (gapCnt_q == '0 && pulseCnt_q == PulseW'(FlushLen)) begin
            DecNd_o      <= 1'b0;
            Busy_o       <= 1'b0;
            Done_o       <= 1'b1;
            ActiveBank_o <= bank_q;
            state_q      <= StIdle;
          end else begin
            Busy_o  <= 1'b1;
            DecNd_o <= (gapCnt_q == '0);
            if (gapCnt_q == '0) pulseCnt_q <= pulseCnt_q + PulseW'(1);
            gapCnt_q <= (gapCnt_q == GapW'(FlushGap - 1)) ? '0 : gapCnt_q + GapW'(1);
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_decimator_coeff_sequencer.sv
// Randomized bench for mac_decimator_coeff_sequencer against a timing-rule reference model.
// Follows COEFF_FLUSH_EN the same way the design does.
module tb_mac_decimator_coeff_sequencer;

  localparam int DataW    = 18;
  localparam int CoeffW   = 18;
  localparam int NumTaps  = 16;
  localparam int AddrW    = 4;
  localparam int NumBanks = 2;
  localparam int BankW    = 1;
  localparam int FlushLen = 16;
  localparam int FlushGap = 16;
`ifdef COEFF_FLUSH_EN
  localparam int Total     = NumTaps + 1 + FlushLen * FlushGap;
  localparam int ExpPulses = FlushLen;
`else
  localparam int Total     = NumTaps + 1;
  localparam int ExpPulses = 0;
`endif

  logic              Clk_i = 1'b0;
  logic              Rst_i;
  logic              HostWr_i;
  logic [BankW-1:0]  HostBank_i;
  logic [AddrW-1:0]  HostAddr_i;
  logic [CoeffW-1:0] HostData_i;
  logic              Load_i;
  logic [BankW-1:0]  BankSel_i;
  logic [DataW-1:0]  Data_i;
  logic              DataNd_i;
  logic [DataW-1:0]  DecData_o;
  logic              DecNd_o;
  logic [AddrW-1:0]  CoeffAddr_o;
  logic [CoeffW-1:0] CoeffData_o;
  logic              CoeffWr_o;
  logic              Busy_o;
  logic              Done_o;
  logic [BankW-1:0]  ActiveBank_o;
  logic [15:0]       DropCnt_o;

  mac_decimator_coeff_sequencer #(
    .DataW(DataW), .CoeffW(CoeffW), .NumTaps(NumTaps), .AddrW(AddrW),
    .NumBanks(NumBanks), .BankW(BankW), .FlushLen(FlushLen), .FlushGap(FlushGap)
  ) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .HostWr_i(HostWr_i), .HostBank_i(HostBank_i),
    .HostAddr_i(HostAddr_i), .HostData_i(HostData_i), .Load_i(Load_i), .BankSel_i(BankSel_i),
    .Data_i(Data_i), .DataNd_i(DataNd_i), .DecData_o(DecData_o), .DecNd_o(DecNd_o),
    .CoeffAddr_o(CoeffAddr_o), .CoeffData_o(CoeffData_o), .CoeffWr_o(CoeffWr_o),
    .Busy_o(Busy_o), .Done_o(Done_o), .ActiveBank_o(ActiveBank_o), .DropCnt_o(DropCnt_o)
  );

  always #5 Clk_i = ~Clk_i;

  int checks, errors, cyc, lastDone, busyPulses;
  logic [CoeffW-1:0] cap5;

  // Reference model: store image plus the reload start edge; outputs follow from elapsed time.
  logic [CoeffW-1:0] mStore [NumBanks][NumTaps];
  bit                mBusy;
  int                mE;
  logic [BankW-1:0]  mBank;
  logic              eDecNd, eWr, eBusy, eDone;
  logic [DataW-1:0]  eDecData;
  logic [AddrW-1:0]  eAddr;
  logic [CoeffW-1:0] eCData;
  logic [BankW-1:0]  eActive;
  logic [15:0]       eDrop;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelStep();
    int rel;
    cyc++;
    if (Rst_i) begin
      mBusy = 0; eDecNd = 0; eDecData = '0; eWr = 0; eAddr = '0; eCData = '0;
      eBusy = 0; eDone = 0; eActive = '0; eDrop = '0;
    end else if (!mBusy) begin
      eDecNd = DataNd_i; eDecData = Data_i; eWr = 0; eBusy = 0; eDone = 0;
      if (Load_i) begin
        mBusy = 1; mE = cyc; mBank = BankSel_i;
      end
    end else begin
      rel = cyc - mE;
      if (DataNd_i && eDrop != 16'hFFFF) eDrop = eDrop + 16'd1;
      eDecNd = 0; eDone = 0;
      if (rel == Total) begin
        eDone = 1; eBusy = 0; eWr = 0; eActive = mBank; mBusy = 0;
      end else begin
        eBusy = 1;
        eWr = (rel <= NumTaps);
        if (eWr) begin
          eAddr  = AddrW'(rel - 1);
          eCData = mStore[mBank][rel - 1];
        end
        if (rel > NumTaps && (rel - NumTaps - 1) % FlushGap == 0 &&
            (rel - NumTaps - 1) / FlushGap < FlushLen) begin
          eDecNd = 1; eDecData = '0;
        end
      end
    end
    if (HostWr_i) mStore[HostBank_i][HostAddr_i] = HostData_i;
  endtask

  task automatic compareAll();
    checkEq("DecNd", 32'(DecNd_o), 32'(eDecNd));
    if (eDecNd) checkEq("DecData", 32'(DecData_o), 32'(eDecData));
    checkEq("CoeffWr", 32'(CoeffWr_o), 32'(eWr));
    checkEq("CoeffAddr", 32'(CoeffAddr_o), 32'(eAddr));
    checkEq("CoeffData", 32'(CoeffData_o), 32'(eCData));
    checkEq("Busy", 32'(Busy_o), 32'(eBusy));
    checkEq("Done", 32'(Done_o), 32'(eDone));
    checkEq("ActiveBank", 32'(ActiveBank_o), 32'(eActive));
    checkEq("DropCnt", 32'(DropCnt_o), 32'(eDrop));
    if (Done_o) lastDone = cyc;
    if (DecNd_o && Busy_o) busyPulses++;
    if (CoeffWr_o && CoeffAddr_o == AddrW'(5)) cap5 = CoeffData_o;
  endtask

  task automatic tick();
    @(posedge Clk_i);
    modelStep();
    #1;
    compareAll();
    @(negedge Clk_i);
  endtask

  task automatic clearIn();
    Rst_i = 0; HostWr_i = 0; HostBank_i = '0; HostAddr_i = '0; HostData_i = '0;
    Load_i = 0; BankSel_i = '0; Data_i = '0; DataNd_i = 0;
  endtask

  task automatic strobe(input int i);
    DataNd_i = (i % 16 == 0);
    Data_i   = DataNd_i ? DataW'(18'h10000) : DataW'($urandom);
  endtask

  // Reload a bank with a 16-cycle upstream strobe; optional mid-reload Load_i and host collision.
  task automatic runReload(input logic [BankW-1:0] bank, input int collideAt, input int midLoadAt);
    int e;
    busyPulses = 0; lastDone = -1;
    Load_i = 1; BankSel_i = bank; strobe(0);
    tick();
    e = cyc;
    for (int r = 1; r <= Total + 3; r++) begin
      strobe(r);
      Load_i = (r == midLoadAt); BankSel_i = ~bank;
      HostWr_i = (r == collideAt); HostBank_i = 1'b1; HostAddr_i = AddrW'(5);
      HostData_i = CoeffW'(18'h3FFFF);
      tick();
    end
    clearIn();
    checkEq("DoneLatency", 32'(lastDone - e), 32'(Total));
    checkEq("BusyPulses", 32'(busyPulses), 32'(ExpPulses));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lastDone = -1; busyPulses = 0; cap5 = '0;
    mBusy = 0; mE = 0; mBank = '0;
    clearIn();
    Rst_i = 1;
    @(negedge Clk_i);
    repeat (3) tick();
    Rst_i = 0;

    // Fill store: bank1 tap k = k+1, bank0 random.
    for (int b = 0; b < NumBanks; b++) begin
      for (int k = 0; k < NumTaps; k++) begin
        strobe(k);
        HostWr_i = 1; HostBank_i = BankW'(b); HostAddr_i = AddrW'(k);
        HostData_i = (b == 1) ? CoeffW'(k + 1) : CoeffW'($urandom);
        tick();
      end
    end
    clearIn();
    for (int i = 0; i < 20; i++) begin
      strobe(i);
      tick();
    end

    runReload(1'b1, -1, 40);
    checkEq("ActiveBankAfter", 32'(ActiveBank_o), 32'(1));
    runReload(1'b1, 6, -1);
    checkEq("CollideOld", 32'(cap5), 32'(6));
    runReload(1'b1, -1, -1);
    checkEq("CollideNew", 32'(cap5), 32'(18'h3FFFF));
    runReload(1'b0, -1, 3);

    // Reset at E+8 aborts, then a fresh reload starts at address 0.
    Load_i = 1; BankSel_i = 1'b1;
    tick();
    Load_i = 0;
    repeat (7) tick();
    Rst_i = 1;
    tick();
    checkEq("RstBusy", 32'(Busy_o), 32'(0));
    Rst_i = 0;
    repeat (4) tick();
    Load_i = 1; BankSel_i = 1'b0;
    tick();
    Load_i = 0;
    tick();
    checkEq("RestartWr", 32'(CoeffWr_o), 32'(1));
    checkEq("RestartAddr", 32'(CoeffAddr_o), 32'(0));
    repeat (Total + 2) tick();

    // Load_i held high: back-to-back reloads.
    Load_i = 1;
    for (int i = 0; i < 2 * Total + 10; i++) begin
      BankSel_i = BankW'($urandom);
      DataNd_i = (i % 3 == 0); Data_i = DataW'($urandom);
      tick();
    end
    clearIn();
    repeat (Total + 2) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      Rst_i      = ($urandom_range(0, 499) == 0);
      HostWr_i   = !Rst_i && ($urandom_range(0, 3) == 0);
      HostBank_i = BankW'($urandom);
      HostAddr_i = AddrW'($urandom);
      HostData_i = CoeffW'($urandom);
      Load_i     = ($urandom_range(0, 39) == 0);
      BankSel_i  = BankW'($urandom);
      DataNd_i   = ($urandom_range(0, 2) == 0);
      Data_i     = DataW'($urandom);
      tick();
    end
    clearIn();
    repeat (Total + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_decimator_coeff_sequencer.md
# mac_decimator_coeff_sequencer

Coefficient bank manager and reload sequencer for the single-MAC decimator. It stores `NumBanks` coefficient sets written by a host port. On request, it streams the selected set into the decimator's coefficient port and can optionally flush the decimator delay line with zero samples. While a reload is in progress it gates the upstream sample stream, dropping and counting samples, so the decimator never filters with a half-written coefficient set. It sits between the sample source and the decimator's `Data_i`/`DataNd_i`/`Coeff*_i` inputs. The decimator's `CoeffClk_i` is tied to `Clk_i`.

## Interface
Parameters:
- `DataW`, 18, sample width
- `CoeffW`, 18, coefficient width
- `NumTaps`, 16, coefficients per set (decimator coefficient RAM depth)
- `AddrW`, 4, coefficient address width, equal to clog2(`NumTaps`)
- `NumBanks`, 2, stored coefficient sets
- `BankW`, 1, bank index width, equal to clog2(`NumBanks`)
- `FlushLen`, 16, zero samples issued per flush
- `FlushGap`, 16, cycles between flush samples (must be ≥ decimator per-sample MAC time)

Ports:
- `Clk_i` in 1: single clock. One clock; reset is synchronous and active-high.
- `Rst_i` in 1: synchronous, active-high reset.
- `HostWr_i` in 1: coefficient store write strobe
- `HostBank_i` in `BankW`: bank written
- `HostAddr_i` in `AddrW`: tap index written
- `HostData_i` in `CoeffW`: coefficient value
- `Load_i` in 1: reload request (level, sampled only in IDLE)
- `BankSel_i` in `BankW`: bank to load, latched with `Load_i`
- `Data_i` in `DataW`: upstream sample
- `DataNd_i` in 1: upstream sample strobe
- `DecData_o` out `DataW`: sample to decimator
- `DecNd_o` out 1: sample strobe to decimator
- `CoeffAddr_o` out `AddrW`: decimator coefficient address
- `CoeffData_o` out `CoeffW`: decimator coefficient data
- `CoeffWr_o` out 1: decimator coefficient write
- `Busy_o` out 1: reload in progress
- `Done_o` out 1: one-cycle pulse at reload completion
- `ActiveBank_o` out `BankW`: bank currently loaded in the decimator
- `DropCnt_o` out 16: upstream samples dropped while busy, saturating

## Operation
- Store: `NumBanks`×`NumTaps` registers of `CoeffW` bits. `HostWr_i` writes the store in any state. The store is not cleared by reset.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - `DecData_o`/`DecNd_o` are registered copies of `Data_i`/`DataNd_i`.
  - `Load_i`=1 latches `BankSel_i`, clears the tap counter, and moves the FSM to LOAD.
- LOAD:
  - Each cycle, drives `CoeffWr_o`=1 with `CoeffAddr_o`=k and `CoeffData_o`=store[bank][k], for k=0..`NumTaps`-1.
  - After k=`NumTaps`-1, moves to FLUSH (macro on) or IDLE with `Done_o` (macro off).
- FLUSH:
  - Issues `FlushLen` pulses of `DecNd_o` with `DecData_o`=0, spaced `FlushGap` cycles apart.
  - Waits `FlushGap` cycles after the last pulse, then moves to IDLE with `Done_o`.
- Busy handling (LOAD or FLUSH):
  - Upstream `DataNd_i` is dropped and `DropCnt_o` increments, saturating at 0xFFFF.
  - `Load_i` is ignored.
- `ActiveBank_o` takes the latched bank in the same cycle `Done_o` pulses.
- Read-before-write: if a host write hits the store entry the loader reads in the same cycle, the loader outputs the old value.
- `CoeffWr_o`=0 outside LOAD. `CoeffAddr_o`/`CoeffData_o` hold their last values.

## Timing
- Reset values: `DecData_o`=0, `DecNd_o`=0, `CoeffAddr_o`=0, `CoeffData_o`=0, `CoeffWr_o`=0, `Busy_o`=0, `Done_o`=0, `ActiveBank_o`=0, `DropCnt_o`=0, state IDLE. Reset mid-reload aborts immediately.
- Passthrough latency: 1 cycle.
- `Load_i` sampled at edge E (IDLE):
  - `Busy_o`=1 and `CoeffWr_o`=1 on cycles E+1..E+`NumTaps`.
  - Flush pulses at E+`NumTaps`+1+i·`FlushGap`, for i=0..`FlushLen`-1.
  - `Done_o`=1 and `Busy_o`=0 at E+`NumTaps`+1+`FlushLen`·`FlushGap` (macro on), or at E+`NumTaps`+1 (macro off).
- `DataNd_i` at edge E together with `Load_i`: the sample is forwarded, not dropped.
- `DataNd_i` in the `Done_o` cycle: forwarded (state is IDLE).
- `Load_i` held high continuously: a new reload starts the cycle after `Done_o`.

## Configuration
- `COEFF_FLUSH_EN` defined: FLUSH state present; timing as above.
- Undefined: FLUSH state and flush counters are compiled out. LOAD goes directly to IDLE. `DecNd_o` is driven only by passthrough.

## Test plan
- Reset, then `DataNd_i` pulse every 16 cycles with `Data_i`=0x10000 -> `DecNd_o`/`DecData_o`=0x10000 one cycle later; `DropCnt_o`=0.
- Host writes bank1 taps k=0..15 with value k+1, `Load_i` with `BankSel_i`=1 at E -> `CoeffWr_o` on E+1..E+16, addr 0..15, data 1..16. With macro on: `Done_o` at E+273 and `ActiveBank_o`=1.
- Macro on: count `DecNd_o` during busy -> exactly 16 pulses, all `DecData_o`=0, 16 cycles apart.
- Upstream strobe every 16 cycles during reload -> no forwarded samples while `Busy_o`=1; `DropCnt_o` equals strobes seen while busy (17 for the default timing); `Load_i` pulse mid-reload has no effect.
- Host write to bank1 addr 5 (value 0x3FFFF) on the exact cycle the loader reads addr 5 -> `CoeffData_o` shows the old value 6; a following reload shows 0x3FFFF.
- `Rst_i` asserted at E+8 -> next cycle all outputs at reset values and state IDLE; the next `Load_i` restarts at addr 0.
